skullfet_cell_tester: RTL and testbench
=======================================

Name: skullfet_cell_tester

Overview:
- Self-checking stimulus/response controller for up to 16 parallel SkullFET cell channels (inverters, buffers or even/odd-length chains) in the user project area.
- Drives a pseudo-random vector onto the cell inputs and waits a programmable settle time.
- Samples the synchronised cell outputs, checks each one against the expected value for its channel mode, and keeps a saturating error counter per channel.
- Sits in user_project_wrapper between the cells and the io/la pins.

Parameters:
- CHANNELS, 4, number of cell channels under test; legal range 1..16.
- CNT_W, 8, width of each per-channel error counter.
- SETTLE_CYCLES, 4, clock cycles between driving a vector and sampling it; legal minimum 2, to cover the synchroniser.
- SEED, 16'hACE1, LFSR reset/start value; must be non-zero.

Ports:
- wb_clk_i  input  1  single clock for the whole block.
- wb_rst_i  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle pulse; begins a run, honoured only in IDLE or DONE.
- stop  input  1  one-cycle pulse; aborts a run and goes to DONE.
- num_vectors  input  16  number of vectors per run; 0 means run until stop.
- mode_inv  input  CHANNELS  per channel: 1 = expect ~stim, 0 = expect stim.
- stim_o  output  CHANNELS  registered drive to the cell inputs.
- resp_i  input  CHANNELS  asynchronous cell outputs.
- busy  output  1  high while a run is in progress.
- done  output  1  high in DONE until the next start.
- err_any  output  1  OR of all error counters being non-zero.
- vec_count  output  16  vectors checked in the current or last run.
- err_count  output  CHANNELS*CNT_W  packed error counters; channel i occupies bits [i*CNT_W +: CNT_W].

Behaviour:
- Reset values: stim_o=0, busy=0, done=0, err_any=0, vec_count=0, err_count all 0, LFSR=SEED, FSM=IDLE, synchroniser flops=0.
- resp_i goes through a 2-flop synchroniser per bit before any use.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1, shift right. It advances only on entry to DRIVE and never reaches 0.
- FSM states:
  - IDLE: outputs quiet. start -> DRIVE; clears vec_count and err_count, reloads LFSR with SEED, busy=1.
  - DRIVE (1 cycle): LFSR advances; stim_o <= next_lfsr[CHANNELS-1:0]. Moves to SETTLE with the settle counter set to SETTLE_CYCLES-1.
  - SETTLE: counts down; at 0 -> SAMPLE.
  - SAMPLE (1 cycle):
    - expected[i] = stim_o[i] ^ mode_inv[i].
    - Any channel whose synchronised resp differs from expected increments its counter, saturating at 2^CNT_W-1.
    - vec_count increments, saturating at 16'hFFFF.
    - If num_vectors!=0 and the new vec_count==num_vectors -> DONE; otherwise -> DRIVE.
  - DONE: busy=0, done=1, stim_o holds its last value, counters hold. start -> DRIVE with the same clearing as from IDLE; done drops in the cycle start is registered.
- Vector period is SETTLE_CYCLES+2 cycles. The first SAMPLE occurs SETTLE_CYCLES+1 cycles after the cycle in which start is registered.
- stop in DRIVE, SETTLE or SAMPLE -> DONE on the next edge. The vector in flight is not counted, unless stop coincides with SAMPLE, in which case that sample is counted first.
- stop in IDLE or DONE is ignored.
- start and stop in the same cycle: stop wins while busy; start wins in IDLE/DONE.
- start while busy is ignored.
- err_any is registered and updates one cycle after the counter change.
- Reset asserted mid-run returns everything to its reset values immediately; no partial results are retained.
- mode_inv is sampled live in SAMPLE. Changing it mid-run is legal and affects only later samples.

Test Plan:
- CHANNELS=4, SETTLE_CYCLES=4, resp_i = ~stim_o on all channels, mode_inv=4'hF, num_vectors=100, start -> done after 600 cycles, vec_count=100, all counters 0, err_any=0.
- Same setup, channel 2 stuck at 0 -> ch2 counter equals the number of vectors with stim_o[2]=0 among the 100 (computed from the LFSR model); other channels 0; err_any=1.
- CNT_W=4, channel 0 forced to wrong polarity, num_vectors=40 -> ch0 counter saturates at 15; vec_count=40.
- num_vectors=0, stop pulsed in the 3rd SETTLE of vector 7 -> DONE on the next edge, vec_count=6, stim_o holds vector 7.
- wb_rst_i asserted asynchronously mid-SETTLE -> all outputs 0 within the same cycle; after release a start reproduces the first vector 0xACE1-derived sequence.
- start pulsed in DONE together with stop -> new run begins, counters cleared, busy=1, done=0.

Source files
------------

// File: rtl/skullfet_cell_tester.sv
// Stimulus/response controller for up to 16 SkullFET cell channels: drives LFSR
// vectors, waits a settle time, checks synchronised responses, counts errors.
module skullfet_cell_tester #(
    parameter int          CHANNELS      = 4,
    parameter int          CNT_W         = 8,
    parameter int          SETTLE_CYCLES = 4,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      start,
    input  logic                      stop,
    input  logic [15:0]               num_vectors,
    input  logic [CHANNELS-1:0]       mode_inv,
    output logic [CHANNELS-1:0]       stim_o,
    input  logic [CHANNELS-1:0]       resp_i,
    output logic                      busy,
    output logic                      done,
    output logic                      err_any,
    output logic [15:0]               vec_count,
    output logic [CHANNELS*CNT_W-1:0] err_count
);

    localparam int SET_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t               state_reg, state_next;
    logic [15:0]          lfsr_reg;
    logic [15:0]          lfsr_next;
    logic [CHANNELS-1:0]  stim_reg;
    logic [CHANNELS-1:0]  resp_meta_reg, resp_sync_reg;
    logic [SET_W-1:0]     settle_reg;
    logic [15:0]          vec_reg;
    logic [15:0]          vec_inc;
    logic                 err_any_reg;
    logic [CHANNELS-1:0]  cnt_nonzero;
    logic                 do_clear, do_drive, do_sample;

    // Galois form, shift right; mask 0xB400 encodes taps 16,14,13,11
    assign lfsr_next = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);
    assign vec_inc   = (vec_reg == 16'hFFFF) ? vec_reg : vec_reg + 16'd1;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        do_clear   = 1'b0;
        do_drive   = 1'b0;
        do_sample  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                done = (state_reg == ST_DONE);
                if (start) begin
                    state_next = ST_DRIVE;
                    do_clear   = 1'b1;
                end
            end
            ST_DRIVE: begin
                busy = 1'b1;
                if (stop) begin
                    state_next = ST_DONE;
                end else begin
                    do_drive   = 1'b1;
                    state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                busy = 1'b1;
                if (stop) begin
                    state_next = ST_DONE;
                end else if (settle_reg == '0) begin
                    state_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                busy      = 1'b1;
                do_sample = 1'b1;
                // a stop landing on the sample still lets that sample count
                if (stop || (num_vectors != 16'd0 && vec_inc == num_vectors)) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_DRIVE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            lfsr_reg      <= SEED;
            stim_reg      <= '0;
            resp_meta_reg <= '0;
            resp_sync_reg <= '0;
            settle_reg    <= '0;
            vec_reg       <= '0;
            err_any_reg   <= 1'b0;
        end else begin
            resp_meta_reg <= resp_i;
            resp_sync_reg <= resp_meta_reg;
            err_any_reg   <= |cnt_nonzero;
            if (do_clear) begin
                lfsr_reg <= SEED;
                vec_reg  <= '0;
            end
            if (do_drive) begin
                lfsr_reg   <= lfsr_next;
                stim_reg   <= lfsr_next[CHANNELS-1:0];
                settle_reg <= SETTLE_LOAD;
            end else if (state_reg == ST_SETTLE && settle_reg != '0) begin
                settle_reg <= settle_reg - SET_W'(1);
            end
            if (do_sample) begin
                vec_reg <= vec_inc;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [CNT_W-1:0] cnt_reg;
            logic             mismatch;

            assign mismatch = resp_sync_reg[gi] != (stim_reg[gi] ^ mode_inv[gi]);

            always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
                if (wb_rst_i) begin
                    cnt_reg <= '0;
                end else if (do_clear) begin
                    cnt_reg <= '0;
                end else if (do_sample && mismatch && cnt_reg != '1) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end

            assign err_count[gi*CNT_W +: CNT_W] = cnt_reg;
            assign cnt_nonzero[gi]              = |cnt_reg;
        end
    endgenerate

    assign stim_o    = stim_reg;
    assign err_any   = err_any_reg;
    assign vec_count = vec_reg;

endmodule

// File: tb/tb_skullfet_cell_tester.sv
// Randomised bench for skullfet_cell_tester: per-run expectations from an LFSR/cell
// model are queued at start; a monitor checks them when done rises.
module tb_skullfet_cell_tester;

    localparam int          CH   = 4;
    localparam int          CW   = 4;
    localparam int          SC   = 4;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          PER  = SC + 2;

    logic              wb_clk_i;
    logic              wb_rst_i;
    logic              start;
    logic              stop;
    logic [15:0]       num_vectors;
    logic [CH-1:0]     mode_inv;
    logic [CH-1:0]     stim_o;
    logic [CH-1:0]     resp_i;
    logic              busy;
    logic              done;
    logic              err_any;
    logic [15:0]       vec_count;
    logic [CH*CW-1:0]  err_count;

    skullfet_cell_tester #(
        .CHANNELS(CH), .CNT_W(CW), .SETTLE_CYCLES(SC), .SEED(SEED)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start(start), .stop(stop),
        .num_vectors(num_vectors), .mode_inv(mode_inv), .stim_o(stim_o),
        .resp_i(resp_i), .busy(busy), .done(done), .err_any(err_any),
        .vec_count(vec_count), .err_count(err_count)
    );

    initial begin
        wb_clk_i = 1'b0;
        forever #5 wb_clk_i = ~wb_clk_i;
    end

    int cyc = 0;
    always @(posedge wb_clk_i) cyc <= cyc + 1;

    // cell behaviour per channel: 0 buffer, 1 inverter, 2 stuck-at-0, 3 stuck-at-1
    logic [1:0] cell_cfg [CH];

    function automatic logic cell_out(input logic [1:0] cfg, input logic s);
        case (cfg)
            2'd0:    return s;
            2'd1:    return ~s;
            2'd2:    return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    always_comb begin
        resp_i = '0;
        for (int i = 0; i < CH; i++) resp_i[i] = cell_out(cell_cfg[i], stim_o[i]);
    end

    typedef struct {
        int          vec;
        logic [15:0] err;
        logic        any;
        logic [3:0]  stim;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int errors = 0;
    int runs_issued = 0;
    int runs_checked = 0;
    int t_start = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    // driven vectors leave stim on the last one; only the first 'counted' are scored
    function automatic exp_t model(input int driven, input int counted, input logic [3:0] mi,
                                   input int lat);
        exp_t        e;
        int          cnt [CH];
        logic [15:0] l;
        logic [3:0]  s;
        l = SEED;
        s = '0;
        for (int c = 0; c < CH; c++) cnt[c] = 0;
        for (int v = 1; v <= driven; v++) begin
            l = lfsr_step(l);
            s = l[3:0];
            if (v <= counted)
                for (int c = 0; c < CH; c++)
                    if (cell_out(cell_cfg[c], s[c]) != (s[c] ^ mi[c]) && cnt[c] < (1 << CW) - 1)
                        cnt[c]++;
        end
        e.vec  = counted;
        e.err  = '0;
        e.any  = 1'b0;
        for (int c = 0; c < CH; c++) begin
            e.err[c*CW +: CW] = cnt[c][CW-1:0];
            if (cnt[c] != 0) e.any = 1'b1;
        end
        e.stim = s;
        e.lat  = lat;
        return e;
    endfunction

    initial begin : monitor
        logic prev;
        int   t1;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge wb_clk_i);
            if (done && !prev) begin
                t1 = cyc;
                @(negedge wb_clk_i);
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    check("vec_count", 32'(vec_count), 32'(e.vec));
                    check("err_count", 32'(err_count), 32'(e.err));
                    check("err_any", 32'(err_any), 32'(e.any));
                    check("stim_hold", 32'(stim_o), 32'(e.stim));
                    check("latency", 32'(t1 - t_start), 32'(e.lat));
                    $display("run %0d: vec=%0d err=%h any=%0d stim=%h lat=%0d", runs_checked,
                             vec_count, err_count, err_any, stim_o, t1 - t_start);
                end
                runs_checked++;
            end
            prev = done;
        end
    end

    task automatic wait_checked(input int budget);
        for (int k = 0; k < budget && runs_checked < runs_issued; k++) @(negedge wb_clk_i);
        if (runs_checked < runs_issued) begin
            check("run_timeout", 32'(runs_checked), 32'(runs_issued));
            sb_q.delete();
            runs_checked = runs_issued;
        end
    endtask

    // stop_vec>0: free-running run, stop in the 3rd SETTLE cycle of that vector
    task automatic do_run(input int n, input logic [3:0] mi, input int stop_vec, input bit with_stop);
        int lat;
        mode_inv    = mi;
        num_vectors = 16'(n);
        if (stop_vec == 0) begin
            lat = n * PER;
            sb_q.push_back(model(n, n, mi, lat));
        end else begin
            lat = 1 + (stop_vec - 1) * PER + 3;
            sb_q.push_back(model(stop_vec, stop_vec - 1, mi, lat));
        end
        runs_issued++;
        @(negedge wb_clk_i);
        start = 1'b1;
        stop  = with_stop;
        @(negedge wb_clk_i);
        start   = 1'b0;
        stop    = 1'b0;
        t_start = cyc;
        if (with_stop) begin
            check("restart_busy", 32'(busy), 32'd1);
            check("restart_done", 32'(done), 32'd0);
            check("restart_vec", 32'(vec_count), 32'd0);
            check("restart_err", 32'(err_count), 32'd0);
            @(negedge wb_clk_i);
            check("restart_err_any", 32'(err_any), 32'd0);
        end
        if (stop_vec != 0) begin
            while (cyc < t_start + lat - 1) @(negedge wb_clk_i);
            stop = 1'b1;
            @(negedge wb_clk_i);
            stop = 1'b0;
        end
        wait_checked(lat + 50);
    endtask

    task automatic set_cfg(input logic [1:0] c0, input logic [1:0] c1, input logic [1:0] c2,
                           input logic [1:0] c3);
        cell_cfg[0] = c0;
        cell_cfg[1] = c1;
        cell_cfg[2] = c2;
        cell_cfg[3] = c3;
    endtask

    initial begin
        wb_rst_i    = 1'b1;
        start       = 1'b0;
        stop        = 1'b0;
        num_vectors = '0;
        mode_inv    = '0;
        set_cfg(2'd1, 2'd1, 2'd1, 2'd1);
        repeat (3) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        check("rst_stim", 32'(stim_o), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err_any", 32'(err_any), 32'd0);
        check("rst_vec", 32'(vec_count), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);

        // stop while idle must be ignored
        stop = 1'b1;
        @(negedge wb_clk_i);
        stop = 1'b0;
        @(negedge wb_clk_i);
        check("idle_stop_done", 32'(done), 32'd0);

        do_run(100, 4'hF, 0, 1'b0);               // all inverters, clean
        set_cfg(2'd1, 2'd1, 2'd2, 2'd1);
        do_run(100, 4'hF, 0, 1'b0);               // ch2 stuck at 0
        set_cfg(2'd0, 2'd1, 2'd1, 2'd1);
        do_run(40, 4'hF, 0, 1'b0);                // ch0 wrong polarity, saturates
        set_cfg(2'd1, 2'd0, 2'd1, 2'd0);
        do_run(12, 4'hF, 0, 1'b1);                // start+stop together in DONE
        set_cfg(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        do_run(0, 4'($urandom), 7, 1'b0);         // stop in vector 7

        // asynchronous reset in the middle of vector 3's settle window
        set_cfg(2'd0, 2'd0, 2'd0, 2'd0);
        mode_inv    = 4'hF;
        num_vectors = 16'd0;
        @(negedge wb_clk_i);
        start = 1'b1;
        @(negedge wb_clk_i);
        start   = 1'b0;
        t_start = cyc;
        while (cyc < t_start + 1 + 2 * PER + 1) @(negedge wb_clk_i);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 wb_rst_i = 1'b1;
        #1;
        check("async_rst_stim", 32'(stim_o), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_vec", 32'(vec_count), 32'd0);
        check("async_rst_err", 32'(err_count), 32'd0);
        check("async_rst_err_any", 32'(err_any), 32'd0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        set_cfg(2'd1, 2'd1, 2'd1, 2'd1);
        do_run(5, 4'hF, 0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            set_cfg(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            do_run($urandom_range(1, 30), 4'($urandom), 0, 1'b0);
        end

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
